// File: rtl/little_box_pkg.sv
// little_box_pkg
//   Shared types for the little_box_sequencer command engine.
//   box_op_e : command opcode carried on cmd_op
//   state_e  : sequencer state; each non-IDLE/RSP state is one box access cycle
//   BOX_ENTRIES : number of entries in the attached register box
package little_box_pkg;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_READ  = 2'b01,
    OP_COPY  = 2'b10,
    OP_SWAP  = 2'b11
  } box_op_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD_A = 3'd1,
    S_RD_B = 3'd2,
    S_WR_A = 3'd3,
    S_WR_B = 3'd4,
    S_RSP  = 3'd5
  } state_e;

  localparam int BOX_ENTRIES = 4;

endpackage

// File: rtl/little_box_sequencer.sv
// little_box_sequencer
//   Initiator-side command engine for a 4-entry register box. Takes one
//   WRITE/READ/COPY/SWAP command at a time, sequences the box's save/load
//   cycles, and returns one response per command.
//
//   Handshakes: a transfer happens on a posedge where valid && ready are both
//   high. The producer holds valid and payload stable until that edge; the
//   consumer may drive ready independently of valid. cmd_ready is high only
//   in IDLE; rsp_valid is high only in RSP and never drops before rsp_ready.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   cmd_valid/ready         command handshake
//   cmd_op/a/b/data         command payload (op, source, destination, data)
//   rsp_valid/ready/data    response handshake and payload
//   box_save/load/addr/in   registered box strobes, address and write data
//   box_out                 combinational box read data
//   busy                    high whenever the engine is not in IDLE
module little_box_sequencer
  import little_box_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_a,
  input  logic [ADDR_W-1:0] cmd_b,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              box_save,
  output logic              box_load,
  output logic [ADDR_W-1:0] box_addr,
  output logic [DATA_W-1:0] box_in,
  input  logic [DATA_W-1:0] box_out,
  output logic              busy
);

  state_e              r_state;
  box_op_e             r_op;
  logic [ADDR_W-1:0]   r_a;
  logic [ADDR_W-1:0]   r_b;
  logic [DATA_W-1:0]   r_data;
  logic [DATA_W-1:0]   r_t0;
  logic [DATA_W-1:0]   r_t1;
  logic                r_cmd_ready;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_data;
  logic                r_box_save;
  logic                r_box_load;
  logic [ADDR_W-1:0]   r_box_addr;
  logic [DATA_W-1:0]   r_box_in;
  logic                r_busy;

  logic                w_accept;
  state_e              w_state_nxt;
  // Effective command fields: on the accept edge the live command inputs are
  // used, so the first state's strobes can be registered on that same edge.
  box_op_e             w_op;
  logic [ADDR_W-1:0]   w_a;
  logic [ADDR_W-1:0]   w_b;
  logic [DATA_W-1:0]   w_data;
  // Temporaries as they will be after this edge; a read captured now feeds
  // the write strobe registered on the same edge.
  logic [DATA_W-1:0]   w_t0_nxt;
  logic [DATA_W-1:0]   w_t1_nxt;

  assign w_accept = (r_state == S_IDLE) && cmd_valid;
  assign w_op     = w_accept ? box_op_e'(cmd_op) : r_op;
  assign w_a      = w_accept ? cmd_a    : r_a;
  assign w_b      = w_accept ? cmd_b    : r_b;
  assign w_data   = w_accept ? cmd_data : r_data;
  assign w_t0_nxt = (r_state == S_RD_A) ? box_out : r_t0;
  assign w_t1_nxt = (r_state == S_RD_B) ? box_out : r_t1;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (cmd_valid) w_state_nxt = (w_op == OP_WRITE) ? S_WR_A : S_RD_A;
      S_RD_A: begin
        case (r_op)
          OP_COPY: w_state_nxt = S_WR_B;
          OP_SWAP: w_state_nxt = S_RD_B;
          default: w_state_nxt = S_RSP;
        endcase
      end
      S_RD_B: w_state_nxt = S_WR_A;
      S_WR_A: w_state_nxt = (r_op == OP_SWAP) ? S_WR_B : S_RSP;
      S_WR_B: w_state_nxt = S_RSP;
      S_RSP:  if (rsp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // All outputs are decoded from the next state so they are glitch-free
  // registers that line up exactly with the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_op        <= OP_WRITE;
      r_a         <= '0;
      r_b         <= '0;
      r_data      <= '0;
      r_t0        <= '0;
      r_t1        <= '0;
      r_cmd_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_box_save  <= 1'b0;
      r_box_load  <= 1'b0;
      r_box_addr  <= '0;
      r_box_in    <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_op   <= w_op;
        r_a    <= cmd_a;
        r_b    <= cmd_b;
        r_data <= cmd_data;
      end
      r_t0 <= w_t0_nxt;
      r_t1 <= w_t1_nxt;

      r_cmd_ready <= (w_state_nxt == S_IDLE);
      r_busy      <= (w_state_nxt != S_IDLE);
      r_rsp_valid <= (w_state_nxt == S_RSP);
      // Payload is captured once on entry to RSP and held through backpressure.
      if ((w_state_nxt == S_RSP) && (r_state != S_RSP))
        r_rsp_data <= (w_op == OP_WRITE) ? w_data : w_t0_nxt;

      r_box_save <= 1'b0;
      r_box_load <= 1'b0;
      r_box_addr <= '0;
      r_box_in   <= '0;
      case (w_state_nxt)
        S_RD_A: begin
          r_box_load <= 1'b1;
          r_box_addr <= w_a;
        end
        S_RD_B: begin
          r_box_load <= 1'b1;
          r_box_addr <= w_b;
        end
        S_WR_A: begin
          r_box_save <= 1'b1;
          r_box_addr <= w_a;
          r_box_in   <= (w_op == OP_WRITE) ? w_data : w_t1_nxt;
        end
        S_WR_B: begin
          r_box_save <= 1'b1;
          r_box_addr <= w_b;
          r_box_in   <= w_t0_nxt;
        end
        default: ;
      endcase
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign box_save  = r_box_save;
  assign box_load  = r_box_load;
  assign box_addr  = r_box_addr;
  assign box_in    = r_box_in;
  assign busy      = r_busy;

endmodule

// File: tb/tb_little_box_sequencer.sv
// tb_little_box_sequencer
//   Drives little_box_sequencer against a simple 4-entry register box and a
//   behavioural model of the box contents. Expected box accesses and
//   responses are queued at issue time; negedge monitors pop and compare.
module tb_little_box_sequencer;
  import little_box_pkg::*;

  localparam int DW = 8;
  localparam int AW = 2;
  localparam int SW = DW + AW + 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          cmd_valid, cmd_ready, rsp_valid, rsp_ready, busy;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_a, cmd_b, box_addr;
  logic [DW-1:0] cmd_data, rsp_data, box_in, box_out;
  logic          box_save, box_load;

  little_box_sequencer #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .box_save(box_save), .box_load(box_load), .box_addr(box_addr),
    .box_in(box_in), .box_out(box_out), .busy(busy)
  );

  // Register box target: write on save at posedge, combinational read.
  logic [DW-1:0] box_mem [4];
  always @(posedge clk) if (box_save) box_mem[box_addr] <= box_in;
  assign box_out = box_load ? box_mem[box_addr] : '0;

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q [$];
  int            lat_q [$];
  int            acc_q [$];
  logic [SW-1:0] strb_q [$];
  logic [DW-1:0] mdl [4];
  int n_cmp = 0;
  int n_bad = 0;
  int last_hs_cyc = -1;
  bit rr_rand = 1'b0;
  bit prev_valid = 1'b0;
  logic [DW-1:0] prev_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic logic [SW-1:0] st(input bit s, input bit l, input logic [AW-1:0] a,
                                       input logic [DW-1:0] d);
    return {s, l, a, d};
  endfunction

  // ---------------- driver ----------------
  // Applies the command's effect to the model, queues expectations, then
  // holds cmd_valid until accepted. acc is the cycle count seen at the
  // negedge right after the accept edge.
  task automatic issue(input box_op_e op, input logic [AW-1:0] a, input logic [AW-1:0] b,
                       input logic [DW-1:0] d, input bit track, output int acc);
    logic [DW-1:0] va, vb, rsp;
    int lat;
    int w;
    va = mdl[a];
    vb = mdl[b];
    rsp = '0;
    lat = 0;
    case (op)
      OP_WRITE: begin
        strb_q.push_back(st(1, 0, a, d));
        mdl[a] = d; rsp = d; lat = 2;
      end
      OP_READ: begin
        strb_q.push_back(st(0, 1, a, va));
        rsp = va; lat = 2;
      end
      OP_COPY: begin
        strb_q.push_back(st(0, 1, a, va));
        strb_q.push_back(st(1, 0, b, va));
        mdl[b] = va; rsp = va; lat = 3;
      end
      default: begin
        strb_q.push_back(st(0, 1, a, va));
        strb_q.push_back(st(0, 1, b, vb));
        strb_q.push_back(st(1, 0, a, vb));
        strb_q.push_back(st(1, 0, b, va));
        mdl[a] = vb; mdl[b] = va; rsp = va; lat = 5;
      end
    endcase
    if (track) begin
      exp_q.push_back(rsp);
      lat_q.push_back(lat);
    end
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_a = a;
    cmd_b = b;
    cmd_data = d;
    w = 0;
    while (!cmd_ready) begin
      @(negedge clk);
      w++;
      if (w > 300) begin
        fail_now("accept_timeout");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "command never accepted");
      end
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    acc = cyc;
    if (track) acc_q.push_back(cyc);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((exp_q.size() != 0 || busy) && w < 500) begin
      @(negedge clk);
      w++;
    end
    if (w >= 500) fail_now("drain_timeout");
    @(negedge clk);
  endtask

  task automatic check_box(input string tag);
    for (int i = 0; i < 4; i++) chk({tag, "_box"}, box_mem[i], mdl[i]);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_data"}, rsp_data, 0);
    chk({tag, "_box_save"}, box_save, 0);
    chk({tag, "_box_load"}, box_load, 0);
    chk({tag, "_box_addr"}, box_addr, 0);
    chk({tag, "_box_in"}, box_in, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      chk("busy_vs_ready", busy, !cmd_ready);
      if (box_save && box_load) fail_now("save_and_load");
      if (!box_save && !box_load) begin
        if (box_addr !== '0 || box_in !== '0) fail_now("idle_addr_in_nonzero");
      end else if (strb_q.size() == 0) begin
        fail_now("unexpected_box_strobe");
      end else begin
        chk("box_strobe", {box_save, box_load, box_addr, box_save ? box_in : box_out},
            strb_q.pop_front());
      end
      if (rsp_valid) begin
        if (!prev_valid) begin
          if (acc_q.size() == 0 || lat_q.size() == 0) fail_now("unexpected_rsp");
          else chk("latency", cyc - acc_q[0] + 1, lat_q[0]);
        end else begin
          chk("rsp_stable", rsp_data, prev_data);
        end
        if (rsp_ready) begin
          if (exp_q.size() == 0) fail_now("rsp_without_expectation");
          else chk("rsp_data", rsp_data, exp_q.pop_front());
          if (lat_q.size() != 0) void'(lat_q.pop_front());
          if (acc_q.size() != 0) void'(acc_q.pop_front());
          last_hs_cyc = cyc;
        end
      end
      prev_valid = rsp_valid && !rsp_ready;
      prev_data = rsp_data;
    end
  end

  // Random response backpressure, changed just after posedge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rr_rand) rsp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #400000;
    fail_now("watchdog");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int acc, acc2, w;
    logic [DW-1:0] old_b;
    cmd_valid = 1'b0;
    cmd_op = '0;
    cmd_a = '0;
    cmd_b = '0;
    cmd_data = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) mdl[i] = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    #2 rst_n = 1'b1;

    // WRITE then preload the remaining entries.
    issue(OP_WRITE, 2'd2, 2'd0, 8'hA5, 1, acc);
    drain();
    chk("write_box2", box_mem[2], 8'hA5);
    issue(OP_WRITE, 2'd1, 2'd0, 8'h3C, 1, acc);
    issue(OP_WRITE, 2'd0, 2'd0, 8'h11, 1, acc);
    issue(OP_WRITE, 2'd3, 2'd0, 8'h22, 1, acc);
    drain();
    check_box("preload");

    issue(OP_READ, 2'd1, 2'd0, 8'h00, 1, acc);
    drain();
    check_box("read");

    issue(OP_COPY, 2'd0, 2'd3, 8'h00, 1, acc);
    drain();
    check_box("copy");

    issue(OP_WRITE, 2'd3, 2'd0, 8'h22, 1, acc);
    issue(OP_SWAP, 2'd0, 2'd3, 8'h00, 1, acc);
    drain();
    chk("swap_box0", box_mem[0], 8'h22);
    chk("swap_box3", box_mem[3], 8'h11);
    issue(OP_SWAP, 2'd3, 2'd3, 8'h00, 1, acc);
    drain();
    check_box("swap_same");

    // Backpressure: response held 4 cycles, second command waits.
    rsp_ready = 1'b0;
    issue(OP_READ, 2'd1, 2'd0, 8'h00, 1, acc);
    fork
      issue(OP_WRITE, 2'd2, 2'd0, 8'h5A, 1, acc2);
      begin
        w = 0;
        while (!rsp_valid && w < 20) begin
          @(negedge clk);
          w++;
        end
        if (w >= 20) fail_now("bp_no_rsp");
        repeat (4) begin
          @(negedge clk);
          chk("bp_rsp_valid", rsp_valid, 1);
          chk("bp_cmd_ready", cmd_ready, 0);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
      end
    join
    chk("bp_accept_after_hs", acc2 > last_hs_cyc, 1);
    drain();
    check_box("bp");

    // Asynchronous reset in the WR_B cycle of a SWAP.
    old_b = mdl[1];
    issue(OP_SWAP, 2'd2, 2'd1, 8'h00, 0, acc);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    mdl[1] = old_b;
    repeat (3) @(negedge clk);
    chk("reset_strobes_consumed", strb_q.size(), 0);
    #2 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_box("after_reset");
    issue(OP_READ, 2'd2, 2'd0, 8'h00, 1, acc);
    drain();

    // Randomised traffic with random response backpressure.
    rr_rand = 1'b1;
    for (int n = 0; n < 60; n++) begin
      issue(box_op_e'($urandom_range(0, 3)), AW'($urandom_range(0, 3)),
            AW'($urandom_range(0, 3)), DW'($urandom_range(0, 255)), 1, acc);
    end
    drain();
    rr_rand = 1'b0;
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    drain();
    check_box("random");
    chk("strobe_queue_empty", strb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
